uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
//
// Pulls WIDTH-bit words from an upstream TX FIFO and serialises each one as
// WIDTH/8 back-to-back UART frames, least significant byte first. Every frame
// is one start bit, 8 data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits. Each bit lasts BAUD_DIV = CLK_FREQ / BAUD_RATE clocks.
//
// Parameters
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  line rate in bit/s
//   WIDTH      FIFO word width, multiple of 8 from 8 to 32
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, ACTIVE-HIGH despite the _n suffix
//   tx_enable   allows a new word to be fetched; a word in flight always finishes
//   fifo_empty  upstream FIFO empty flag, looked at only while idle
//   fifo_dout   upstream FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  registered one-cycle read strobe
//   tx          serial line, idle high
//   busy        high whenever the framer is not idle
//   word_done   one-cycle pulse on the first idle cycle after a word's last stop bit
// -----------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int WIDTH     = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             word_done
);

    // Ceiling log2, never below 1 so that degenerate sizes still give a
    // legal one-bit counter.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W    = clogb2(BAUD_DIV);
    localparam int NBYTES   = WIDTH / 8;
    localparam int BIDX_W   = clogb2(NBYTES);

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(NBYTES - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    baud_q,  baud_d;
    // Data bit index in DATA, stop bit index in STOP.
    logic [2:0]          bit_q,   bit_d;
    logic [BIDX_W-1:0]   byte_q,  byte_d;
    logic [WIDTH-1:0]    word_q,  word_d;
    logic                done_d;
    logic                tx_d;
    // Set on the first clock after reset; holds off the first FETCH until
    // the second rising edge so the FIFO flags have settled.
    logic                armed_q;

    logic                baud_end;
    logic [7:0]          byte_val;
    logic                par_bit;

    assign baud_end = (baud_q == BAUD_LAST);
    assign busy     = (state_q != ST_IDLE);

    // -------------------------------------------------------------------------
    // State register. tx is a flop with an asynchronous preset so the line is
    // forced idle the moment reset asserts, without needing a clock.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            word_q     <= '0;
            armed_q    <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            armed_q    <= 1'b1;
            tx         <= tx_d;
            fifo_rd_en <= (state_d == ST_FETCH);
            word_done  <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. The baud counter restarts from 0 on every bit and
    // state change, so each bit is exactly BAUD_DIV clocks with no drift.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                if (armed_q && tx_enable && !fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                word_d  = fifo_dout;
                byte_d  = '0;
                bit_d   = '0;
                baud_d  = '0;
                state_d = ST_START;
            end

            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (byte_q == BYTE_LAST) begin
                            // word_done is registered, so it is seen in the
                            // first IDLE cycle, together with busy dropping.
                            byte_d  = '0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            // Next byte follows immediately, no idle gap.
                            byte_d  = byte_q + BIDX_W'(1);
                            state_d = ST_START;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                byte_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Line value for the coming cycle, derived from the next state so tx can
    // be a clean flop. In LOAD the next state is START, so the freshly loaded
    // word is never needed on the same cycle it is captured.
    // -------------------------------------------------------------------------
    always_comb begin
        byte_val = 8'(word_d >> {byte_d, 3'b000});
        // Even: XOR of the data bits. Odd: its inverse.
        par_bit  = (PARITY == 1) ? ~(^byte_val) : ^byte_val;

        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = byte_val[bit_d];
            ST_PARITY: tx_d = par_bit;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Three framer instances with different word width / parity / stop-bit
// settings run side by side. Each has a FIFO model feeding it, a stimulus
// process pushing words (and the expected words into a scoreboard queue), and
// a line receiver that, on every start bit, pops the next expected word and
// checks the serial waveform cycle by cycle against the framing rules.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

  localparam int CLK_F = 1000;
  localparam int BAUD  = 100;
  localparam int BD    = CLK_F / BAUD;
  localparam int NCFG  = 3;
  localparam int LIMIT = 60000;

  // Per-configuration settings, index 0 in the low byte.
  localparam logic [NCFG-1:0][7:0] WA = {8'd32, 8'd8, 8'd16};
  localparam logic [NCFG-1:0][7:0] PA = {8'd1,  8'd2, 8'd0};
  localparam logic [NCFG-1:0][7:0] SA = {8'd1,  8'd2, 8'd1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int g, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s [cfg%0d] at cycle %0d: got %0d, expected %0d", nm, g, cyc, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W    = int'(WA[g]);
    localparam int P    = int'(PA[g]);
    localparam int S    = int'(SA[g]);
    localparam int NB   = W / 8;
    localparam int BITS = 1 + 8 + ((P != 0) ? 1 : 0) + S;
    localparam int FLEN = NB * BITS * BD;

    logic         rst_n      = 1'b1;
    logic         tx_enable  = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [W-1:0] fifo_dout  = '0;
    logic         fifo_rd_en, tx, busy, word_done;

    logic [W-1:0] fifoq[$];
    logic [W-1:0] expq[$];
    int  rd_cnt    = 0;
    int  rd_cyc    = 0;
    int  done_cnt  = 0;
    logic rd_prev  = 1'b0;
    bit  stim_done = 1'b0;

    uart_tx_framer #(
      .CLK_FREQ(CLK_F), .BAUD_RATE(BAUD), .WIDTH(W), .PARITY(P), .STOP_BITS(S)
    ) dut (
      .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
      .word_done(word_done)
    );

    // Reference: value of bit j of the serialised word, from the framing rules.
    function automatic logic exp_bit(input logic [W-1:0] w, input int j);
      int bi, p;
      logic [7:0] b;
      bi = j / BITS;
      p  = j % BITS;
      b  = 8'(w >> (8 * bi));
      if (p == 0) return 1'b0;
      if (p <= 8) return b[p-1];
      if (P != 0 && p == 9) return (P == 2) ? ^b : ~(^b);
      return 1'b1;
    endfunction

    task automatic push(input logic [31:0] v);
      fifoq.push_back(W'(v));
      expq.push_back(W'(v));
    endtask

    task automatic wait_start(input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end while (tx !== 1'b0 && n < lim);
      chk("start_timeout", g, n < lim, 1);
    endtask

    task automatic wait_idle(input int left, input int lim);
      int n = 0;
      do begin @(negedge clk); n++; end
      while (!(expq.size() == left && busy === 1'b0) && n < lim);
      chk("idle_timeout", g, n < lim, 1);
      repeat (4) @(negedge clk);
    endtask

    // FIFO model: registered read data and registered empty flag.
    always @(posedge clk) begin
      if (fifo_rd_en === 1'b1) begin
        chk("rd_nonempty", g, fifoq.size() > 0, 1);
        if (fifoq.size() > 0) fifo_dout <= fifoq.pop_front();
      end
      fifo_empty <= (fifoq.size() == 0);
    end

    // Read strobe / word_done bookkeeping.
    always @(negedge clk) begin
      rd_prev <= fifo_rd_en;
      if (fifo_rd_en === 1'b1) begin
        chk("rd_single_cycle", g, rd_prev, 0);
        rd_cnt <= rd_cnt + 1;
        rd_cyc <= cyc;
      end
      if (word_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Line receiver / scoreboard consumer.
    initial begin : monitor
      logic [W-1:0] w;
      int     start, last_end;
      bit     b2b, aborted;
      longint got;
      logic   eb;
      last_end = 0;
      b2b = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_n === 1'b0 && tx === 1'b0) begin
          start = cyc;
          chk("rd_to_start", g, start - rd_cyc, 2);
          if (b2b) chk("word_gap", g, start - last_end - 1, 3);
          b2b = 1'b0;
          chk("frame_expected", g, expq.size() > 0, 1);
          if (expq.size() > 0) begin
            w = expq.pop_front();
            aborted = 1'b0;
            for (int j = 0; j < NB * BITS && !aborted; j++) begin
              eb  = exp_bit(w, j);
              got = eb;
              for (int k = 0; k < BD; k++) begin
                if (j > 0 || k > 0) @(negedge clk);
                if (rst_n !== 1'b0) begin aborted = 1'b1; break; end
                if (tx !== eb) got = (tx === 1'b1) ? 1 : (tx === 1'b0) ? 0 : 2;
              end
              if (!aborted) chk("frame_bit", g, got, eb);
            end
            if (!aborted) begin
              @(negedge clk);
              if (rst_n === 1'b0) begin
                chk("word_done", g, word_done, 1);
                chk("idle_after_word", g, busy, 0);
                last_end = cyc - 1;
                b2b = tx_enable && !fifo_empty;
              end
            end
          end
        end
      end
    end

    initial begin : stim
      int r0, d0;
      push(32'h0000A55A);
      repeat (3) @(negedge clk);
      chk("reset_outputs", g, {tx, busy, fifo_rd_en, word_done}, 4'b1000);

      // Out of reset with fetching disabled: nothing happens.
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (30) @(negedge clk);
      chk("disabled_idle", g, {tx, busy}, 2'b10);
      chk("disabled_no_fetch", g, rd_cnt, 0);

      // Enable during reset, release, and check the start-up hold-off.
      @(posedge clk); #1 rst_n = 1'b1; tx_enable = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("startup_holdoff", g, fifo_rd_en, 0);
      wait_idle(0, 5 * FLEN);

      // Two words queued together: back-to-back with the minimum gap.
      r0 = rd_cnt; d0 = done_cnt;
      push(32'h00001234);
      push(32'hFFFFFFFF);
      wait_idle(0, 5 * FLEN);
      chk("b2b_fetches", g, rd_cnt - r0, 2);
      chk("b2b_done_pulses", g, done_cnt - d0, 2);

      // Parity corner: every byte 0x07.
      push(32'h07070707);
      wait_idle(0, 5 * FLEN);

      // Drop tx_enable during bit 3 of byte 0: word finishes, next is held.
      r0 = rd_cnt;
      push($urandom);
      push($urandom);
      wait_start(4 * FLEN);
      repeat (4 * BD + 2) @(negedge clk);
      @(posedge clk); #1 tx_enable = 1'b0;
      wait_idle(1, 5 * FLEN);
      repeat (3 * BD) @(negedge clk);
      chk("drop_one_fetch", g, rd_cnt - r0, 1);
      chk("drop_holds_fifo", g, fifoq.size(), 1);
      chk("drop_idle", g, busy, 0);
      @(posedge clk); #1 tx_enable = 1'b1;
      wait_idle(0, 5 * FLEN);

      // Random words, random spacing, random enable.
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        push($urandom);
        tx_enable = ($urandom_range(3, 0) != 0);
        repeat ($urandom_range(FLEN + 20, 0)) @(posedge clk);
      end
      #1 tx_enable = 1'b1;
      wait_idle(0, 12 * FLEN);

      // Reset during data bit 5 of byte 0 (bit forced 0 so the jump shows).
      r0 = rd_cnt;
      push($urandom & 32'hFFFFFFDF);
      wait_start(4 * FLEN);
      repeat (6 * BD + 4) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      #1 chk("reset_async_line", g, {tx, busy}, 2'b10);
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (4 * BD) @(negedge clk);
      chk("reset_no_refetch", g, rd_cnt - r0, 1);
      chk("reset_stays_idle", g, {tx, busy}, 2'b10);
      stim_done = 1'b1;
    end
  end

  initial begin : finisher
    int t;
    t = 0;
    while (!(cfg[0].stim_done && cfg[1].stim_done && cfg[2].stim_done) && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    chk("run_complete", 0, t < LIMIT, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
